// File: rtl/dram_pkg.sv
// Shared DRAM word layout, diag load codes and loader states for the IR dispatch RAM.
// Used by dram_loader and by the IR stage for word unpacking.
package dram_pkg;

    localparam int DRAM_WIDTH     = 15;
    localparam int DRAM_ADDR_BITS = 9;
    localparam int PAIR_BITS      = DRAM_ADDR_BITS - 1;

    localparam logic [6:0] DIAG_LOAD_XY_EVEN = 7'o60;
    localparam logic [6:0] DIAG_LOAD_XY_ODD  = 7'o61;
    localparam logic [6:0] DIAG_LOAD_JCOM    = 7'o62;
    localparam logic [6:0] DIAG_LOAD_J_EVEN  = 7'o63;
    localparam logic [6:0] DIAG_LOAD_J_ODD   = 7'o64;

    localparam logic [0:4] MASK_FULL = 5'b11111;

    typedef struct packed {
        logic [0:2]  a;
        logic [0:2]  b;
        logic        par;
        logic [1:4]  jcom;
        logic [7:10] j;
    } tDRAMword;

    typedef enum logic [1:0] {
        IDLE,
        WR_EVEN,
        WR_ODD
    } tLoaderState;

    // Mask bit 0 corresponds to code 060, bit 4 to code 064; unknown codes map to no bit.
    function automatic logic [0:4] diag_func_bit(input logic [6:0] code);
        case (code)
            DIAG_LOAD_XY_EVEN: return 5'b10000;
            DIAG_LOAD_XY_ODD:  return 5'b01000;
            DIAG_LOAD_JCOM:    return 5'b00100;
            DIAG_LOAD_J_EVEN:  return 5'b00010;
            DIAG_LOAD_J_ODD:   return 5'b00001;
            default:           return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/dram_word_parity.sv
// Combinational odd-parity helper for one DRAM word: par_gen is the PAR value
// that gives the whole word odd parity; a supplied word checks good when PAR equals it.
module dram_word_parity
    import dram_pkg::*;
(
    input  tDRAMword data,
    output logic     par_gen
);

    // Removing the supplied PAR from the full-word XOR leaves the XOR of the other 14 bits.
    assign par_gen = ~((^data) ^ data.par);

endmodule

// File: rtl/dram_loader.sv
// Diagnostic loader for the IR dispatch RAM: gathers diag functions 060..064 for one
// even/odd pair, then writes both words. Define DRAM_LOADER_PARGEN_EN to generate PAR.
module dram_loader
    import dram_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      diagStrobe,
    input  logic [0:6]                diagFunc,
    input  logic [0:35]               ebusData,
    output logic [DRAM_ADDR_BITS-1:0] dramAddr,
    output logic [DRAM_WIDTH-1:0]     dramDin,
    output logic                      dramWe,
    output logic                      busy,
    output logic                      done,
    output logic                      seqErr,
    output logic                      parErr,
    input  logic                      errClr
);

    tLoaderState state, state_next;

    logic [0:4]           mask, mask_next;
    logic [PAIR_BITS-1:0] pair;
    logic [0:2]           even_a, even_b, odd_a, odd_b;
    logic                 even_par, odd_par;
    logic [1:4]           jcom;
    logic [7:10]          j_even, j_odd;

    logic [0:4]           func_bit;
    logic                 accepted;
    logic [PAIR_BITS-1:0] strobe_pair;
    logic                 pair_mismatch;
    logic                 seq_err_set;
    logic                 par_err_set;

    tDRAMword even_raw, odd_raw, even_word, odd_word;
    logic     even_gen, odd_gen;

    assign func_bit      = diag_func_bit(diagFunc);
    assign accepted      = diagStrobe && (func_bit != 5'b00000);
    assign strobe_pair   = ebusData[27:34];
    assign pair_mismatch = (mask != 5'b00000) && (strobe_pair != pair);

    assign even_raw = {even_a, even_b, even_par, jcom, j_even};
    assign odd_raw  = {odd_a, odd_b, odd_par, jcom, j_odd};

    dram_word_parity u_even_parity (
        .data    (even_raw),
        .par_gen (even_gen)
    );

    dram_word_parity u_odd_parity (
        .data    (odd_raw),
        .par_gen (odd_gen)
    );

`ifdef DRAM_LOADER_PARGEN_EN
    always_comb begin
        even_word     = even_raw;
        odd_word      = odd_raw;
        even_word.par = even_gen;
        odd_word.par  = odd_gen;
    end

    assign par_err_set = 1'b0;
`else
    assign even_word = even_raw;
    assign odd_word  = odd_raw;

    // Bad words are still written; the error only reports them.
    assign par_err_set = ((state == WR_EVEN) && (even_raw.par != even_gen)) ||
                         ((state == WR_ODD)  && (odd_raw.par  != odd_gen));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mask_next   = mask;
        seq_err_set = 1'b0;
        dramWe      = 1'b0;
        busy        = 1'b0;
        dramAddr    = '0;
        dramDin     = '0;
        case (state)
            IDLE: begin
                if (accepted) begin
                    // A new pair address restarts collection with this strobe as its first function.
                    if (pair_mismatch) begin
                        seq_err_set = 1'b1;
                        mask_next   = func_bit;
                    end else begin
                        mask_next = mask | func_bit;
                    end
                    if (mask_next == MASK_FULL) begin
                        state_next = WR_EVEN;
                    end
                end
            end
            WR_EVEN: begin
                busy        = 1'b1;
                dramWe      = 1'b1;
                dramAddr    = {pair, 1'b0};
                dramDin     = even_word;
                seq_err_set = accepted;
                state_next  = WR_ODD;
            end
            WR_ODD: begin
                busy        = 1'b1;
                dramWe      = 1'b1;
                dramAddr    = {pair, 1'b1};
                dramDin     = odd_word;
                seq_err_set = accepted;
                mask_next   = 5'b00000;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= 5'b00000;
            pair     <= '0;
            even_a   <= '0;
            even_b   <= '0;
            even_par <= 1'b0;
            odd_a    <= '0;
            odd_b    <= '0;
            odd_par  <= 1'b0;
            jcom     <= '0;
            j_even   <= '0;
            j_odd    <= '0;
            done     <= 1'b0;
            seqErr   <= 1'b0;
            parErr   <= 1'b0;
        end else begin
            mask   <= mask_next;
            done   <= (state == WR_ODD);
            seqErr <= (seqErr && !errClr) || seq_err_set;
            parErr <= (parErr && !errClr) || par_err_set;
            if ((state == IDLE) && accepted) begin
                pair <= strobe_pair;
                case (diagFunc)
                    DIAG_LOAD_XY_EVEN: begin
                        even_a   <= ebusData[0:2];
                        even_b   <= ebusData[3:5];
                        even_par <= ebusData[6];
                    end
                    DIAG_LOAD_XY_ODD: begin
                        odd_a   <= ebusData[0:2];
                        odd_b   <= ebusData[3:5];
                        odd_par <= ebusData[6];
                    end
                    DIAG_LOAD_JCOM:   jcom   <= ebusData[0:3];
                    DIAG_LOAD_J_EVEN: j_even <= ebusData[0:3];
                    DIAG_LOAD_J_ODD:  j_odd  <= ebusData[0:3];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dram_loader.sv
// Scoreboard bench for dram_loader: expected DRAM writes are queued by the stimulus
// and popped by a monitor whenever dramWe is seen; status outputs are checked directly.
module tb_dram_loader;

    logic        clk;
    logic        reset;
    logic        diagStrobe;
    logic [0:6]  diagFunc;
    logic [0:35] ebusData;
    logic [8:0]  dramAddr;
    logic [14:0] dramDin;
    logic        dramWe;
    logic        busy;
    logic        done;
    logic        seqErr;
    logic        parErr;
    logic        errClr;

    typedef struct {
        logic [8:0]  addr;
        logic [14:0] din;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    localparam logic [14:0] W1_EVEN     = 15'b011_101_0_1001_0010;
    localparam logic [14:0] W1_ODD      = 15'b011_101_0_1001_0111;
    localparam logic [14:0] W1_EVEN_BAD = 15'b011_101_1_1001_0010;
    localparam logic [14:0] W2_EVEN     = 15'b001_010_0_0000_0001;
    localparam logic [14:0] W2_ODD      = 15'b111_000_0_0000_0000;

    dram_loader dut (
        .clk        (clk),
        .reset      (reset),
        .diagStrobe (diagStrobe),
        .diagFunc   (diagFunc),
        .ebusData   (ebusData),
        .dramAddr   (dramAddr),
        .dramDin    (dramDin),
        .dramWe     (dramWe),
        .busy       (busy),
        .done       (done),
        .seqErr     (seqErr),
        .parErr     (parErr),
        .errClr     (errClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [0:35] xyData(input logic [2:0] a, input logic [2:0] b,
                                           input logic par, input logic [7:0] pr);
        logic [0:35] d;
        d        = '0;
        d[0:2]   = a;
        d[3:5]   = b;
        d[6]     = par;
        d[27:34] = pr;
        return d;
    endfunction

    function automatic logic [0:35] jData(input logic [3:0] j, input logic [7:0] pr);
        logic [0:35] d;
        d        = '0;
        d[0:3]   = j;
        d[27:34] = pr;
        return d;
    endfunction

    task automatic applyStimulus(input logic [6:0] code, input logic [0:35] data);
        @(posedge clk);
        #1;
        diagStrobe = 1'b1;
        diagFunc   = code;
        ebusData   = data;
        @(posedge clk);
        #1;
        diagStrobe = 1'b0;
    endtask

    task automatic pulseErrClr();
        @(posedge clk);
        #1;
        errClr = 1'b1;
        @(posedge clk);
        #1;
        errClr = 1'b0;
    endtask

    // Called right after the last strobe has been sampled.
    task automatic waitDone(input string tag);
        @(negedge clk);
        checkOutput({tag, "_busy_even"}, busy, 1);
        @(negedge clk);
        checkOutput({tag, "_done_early"}, done, 0);
        @(negedge clk);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic loadPair1(input logic [7:0] pr, input logic even_par_bit);
        applyStimulus(7'o60, xyData(3'd3, 3'd5, even_par_bit, pr));
        applyStimulus(7'o61, xyData(3'd3, 3'd5, 1'b0, pr));
        applyStimulus(7'o62, jData(4'o11, pr));
        applyStimulus(7'o63, jData(4'd2, pr));
        applyStimulus(7'o64, jData(4'd7, pr));
    endtask

    always @(negedge clk) begin
        if (dramWe) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write_addr", {23'd0, dramAddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("write_addr", {23'd0, dramAddr}, {23'd0, e.addr});
                checkOutput("write_din", {17'd0, dramDin}, {17'd0, e.din});
            end
        end
    end

    initial begin
        logic       exp_par_err;
        logic       exp_word_parity;
        logic [14:0] exp_even_bad;
`ifdef DRAM_LOADER_PARGEN_EN
        exp_par_err     = 1'b0;
        exp_word_parity = 1'b1;
        exp_even_bad    = W1_EVEN;
`else
        exp_par_err     = 1'b1;
        exp_word_parity = 1'b0;
        exp_even_bad    = W1_EVEN_BAD;
`endif
        reset      = 1'b1;
        diagStrobe = 1'b0;
        diagFunc   = '0;
        ebusData   = '0;
        errClr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_we", dramWe, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_seqErr", seqErr, 0);
        checkOutput("rst_parErr", parErr, 0);
        checkOutput("rst_addr", {23'd0, dramAddr}, 0);
        checkOutput("rst_din", {17'd0, dramDin}, 0);
        reset = 1'b0;

        $display("[TB] forward order, pair 0o12, with an ignored code in the middle");
        exp_q.push_back('{9'o24, W1_EVEN});
        exp_q.push_back('{9'o25, W1_ODD});
        applyStimulus(7'o60, xyData(3'd3, 3'd5, 1'b0, 8'o12));
        applyStimulus(7'o61, xyData(3'd3, 3'd5, 1'b0, 8'o12));
        applyStimulus(7'o62, jData(4'o11, 8'o12));
        applyStimulus(7'o65, jData(4'hF, 8'o77));
        applyStimulus(7'o63, jData(4'd2, 8'o12));
        applyStimulus(7'o64, jData(4'd7, 8'o12));
        waitDone("fwd");
        checkOutput("fwd_seqErr", seqErr, 0);

        $display("[TB] reverse order");
        exp_q.push_back('{9'o24, W1_EVEN});
        exp_q.push_back('{9'o25, W1_ODD});
        applyStimulus(7'o64, jData(4'd7, 8'o12));
        applyStimulus(7'o63, jData(4'd2, 8'o12));
        applyStimulus(7'o62, jData(4'o11, 8'o12));
        applyStimulus(7'o61, xyData(3'd3, 3'd5, 1'b0, 8'o12));
        applyStimulus(7'o60, xyData(3'd3, 3'd5, 1'b0, 8'o12));
        waitDone("rev");

        $display("[TB] pair address change");
        applyStimulus(7'o60, xyData(3'd5, 3'd5, 1'b1, 8'd1));
        applyStimulus(7'o61, xyData(3'd7, 3'd0, 1'b0, 8'd2));
        checkOutput("addrchg_seqErr", seqErr, 1);
        pulseErrClr();
        checkOutput("addrchg_seqErr_clr", seqErr, 0);
        exp_q.push_back('{9'd4, W2_EVEN});
        exp_q.push_back('{9'd5, W2_ODD});
        applyStimulus(7'o62, jData(4'd0, 8'd2));
        applyStimulus(7'o63, jData(4'd1, 8'd2));
        applyStimulus(7'o64, jData(4'd0, 8'd2));
        applyStimulus(7'o60, xyData(3'd1, 3'd2, 1'b0, 8'd2));
        waitDone("addrchg");
        checkOutput("addrchg_seqErr_after", seqErr, 0);

        $display("[TB] strobe while busy");
        exp_q.push_back('{9'd6, W1_EVEN});
        exp_q.push_back('{9'd7, W1_ODD});
        loadPair1(8'd3, 1'b0);
        diagStrobe = 1'b1;
        diagFunc   = 7'o62;
        ebusData   = jData(4'd0, 8'd3);
        @(negedge clk);
        checkOutput("busy_strobe_busy", busy, 1);
        @(posedge clk);
        #1;
        diagStrobe = 1'b0;
        @(negedge clk);
        checkOutput("busy_strobe_seqErr", seqErr, 1);
        checkOutput("busy_strobe_done_early", done, 0);
        @(negedge clk);
        checkOutput("busy_strobe_done", done, 1);

        $display("[TB] reset during the even write");
        exp_q.push_back('{9'd8, W1_EVEN});
        loadPair1(8'd4, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_we", dramWe, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_seqErr", seqErr, 0);
        checkOutput("midrst_addr", {23'd0, dramAddr}, 0);
        checkOutput("midrst_din", {17'd0, dramDin}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_done", done, 0);

        $display("[TB] even word supplied with even parity");
        exp_q.push_back('{9'd10, exp_even_bad});
        exp_q.push_back('{9'd11, W1_ODD});
        loadPair1(8'd5, 1'b1);
        @(negedge clk);
        checkOutput("par_even_word_parity", ^dramDin, exp_word_parity);
        @(negedge clk);
        checkOutput("par_parErr", parErr, exp_par_err);
        @(negedge clk);
        checkOutput("par_done", done, 1);
        pulseErrClr();
        checkOutput("par_parErr_clr", parErr, 0);

        repeat (3) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
